// File: rtl/timer_pkg.sv
// Shared types, constants and key encoder for the microwave timer display path.
package timer_pkg;

    localparam int unsigned KEY_W        = 10;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned BCD_MAX_ONES = 9;
    localparam int unsigned BCD_MAX_TENS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [DIGIT_W-1:0] digit;
    } key_code_t;

    // Encode a one-hot keypad vector to BCD; valid only when exactly one key is set.
    function automatic key_code_t onehot_to_bcd(input logic [KEY_W-1:0] keys);
        key_code_t   res;
        int unsigned hits;
        res  = '0;
        hits = 0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (keys[i]) begin
                hits++;
                res.digit = DIGIT_W'(i);
            end
        end
        res.valid = (hits == 1);
        return res;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Control inputs and BCD display outputs between the oven controller and the timer.
interface timer_counter_if;
    import timer_pkg::*;

    logic [KEY_W-1:0]   keypad;
    logic               start;
    logic               stop_clear;
    logic               door_closed;
    logic               tick_1hz;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] min;
    logic               running;
    logic               done;

    modport master (
        output keypad, start, stop_clear, door_closed, tick_1hz,
        input  sec_ones, sec_tens, min, running, done
    );

    modport slave (
        input  keypad, start, stop_clear, door_closed, tick_1hz,
        output sec_ones, sec_tens, min, running, done
    );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load; wraps to max_val and borrows at 0.
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               dec_en,
    input  logic [DIGIT_W-1:0] max_val,
    output logic [DIGIT_W-1:0] value,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] r_value;

    assign value      = r_value;
    assign borrow_out = dec_en && (r_value == '0);

    // Load has priority over decrement; decrement from 0 wraps to max_val.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (dec_en) begin
            r_value <= (r_value == '0) ? max_val : r_value - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/timer_counter.sv
// M:SS microwave timer: keypad digit entry, 1 Hz countdown, done pulse at 0:00.
// Optional macro PRESCALE_EN: derive the 1 Hz tick internally from CLK_HZ.
module timer_counter #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned MAX_MIN = 9
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);
    import timer_pkg::*;

    state_t             r_state;
    logic [KEY_W-1:0]   r_keypad;
    logic               r_running;
    logic               r_done;

    key_code_t          w_key;
    logic               w_edit;
    logic               w_press;
    logic               w_key_ok;
    logic               w_clear;
    logic               w_load;
    logic               w_tick;
    logic               w_time_zero;
    logic               w_time_last;
    logic               w_dec;
    logic               w_borrow_ones;
    logic               w_borrow_tens;
    logic               w_unused_borrow_min;
    logic [DIGIT_W-1:0] w_ones_ld;
    logic [DIGIT_W-1:0] w_tens_ld;
    logic [DIGIT_W-1:0] w_min_ld;

    assign bus.running = r_running;
    assign bus.done    = r_done;

    // Key press = rising edge of "any key"; only a clean one-hot press is accepted.
    assign w_key    = onehot_to_bcd(bus.keypad);
    assign w_edit   = (r_state == IDLE) || (r_state == PAUSE);
    assign w_press  = (bus.keypad != '0) && (r_keypad == '0);
    assign w_key_ok = w_edit && w_press && w_key.valid;
    assign w_clear  = w_edit && bus.stop_clear;
    assign w_load   = w_clear || w_key_ok;

    // Shift-in values: each digit takes its right neighbour, saturated to its range.
    assign w_ones_ld = w_clear ? '0 : w_key.digit;
    assign w_tens_ld = w_clear ? '0 :
                       (bus.sec_ones > DIGIT_W'(BCD_MAX_TENS)) ? DIGIT_W'(BCD_MAX_TENS) : bus.sec_ones;
    assign w_min_ld  = w_clear ? '0 :
                       (bus.sec_tens > DIGIT_W'(MAX_MIN)) ? DIGIT_W'(MAX_MIN) : bus.sec_tens;

    assign w_time_zero = (bus.min == '0) && (bus.sec_tens == '0) && (bus.sec_ones == '0);
    assign w_time_last = (bus.min == '0) && (bus.sec_tens == '0) && (bus.sec_ones == DIGIT_W'(1));

    // Pause conditions (stop_clear, door open) suppress the tick in the same cycle.
    assign w_dec = (r_state == RUN) && bus.door_closed && !bus.stop_clear && w_tick && !w_time_zero;

`ifdef PRESCALE_EN
    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CNT_W-1:0] r_presc;
    logic             w_unused_tick_1hz;

    assign w_unused_tick_1hz = bus.tick_1hz;
    assign w_tick            = (r_presc == CNT_W'(CLK_HZ - 1));

    // Held at 0 outside RUN so every (re)start waits a full second for the first tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if ((r_state != RUN) || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + CNT_W'(1);
        end
    end
`else
    logic [31:0] w_unused_clk_hz;

    assign w_unused_clk_hz = 32'(CLK_HZ);
    assign w_tick          = bus.tick_1hz;
`endif

    // Seconds-ones digit; its borrow drives the tens digit.
    bcd_down_digit u_sec_ones (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_val   (w_ones_ld),
        .dec_en     (w_dec),
        .max_val    (DIGIT_W'(BCD_MAX_ONES)),
        .value      (bus.sec_ones),
        .borrow_out (w_borrow_ones)
    );

    // Seconds-tens digit; its borrow drives the minutes digit.
    bcd_down_digit u_sec_tens (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_val   (w_tens_ld),
        .dec_en     (w_borrow_ones),
        .max_val    (DIGIT_W'(BCD_MAX_TENS)),
        .value      (bus.sec_tens),
        .borrow_out (w_borrow_tens)
    );

    // Minutes digit; never borrows because decrement is blocked at 0:00.
    bcd_down_digit u_min (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_val   (w_min_ld),
        .dec_en     (w_borrow_tens),
        .max_val    (DIGIT_W'(MAX_MIN)),
        .value      (bus.min),
        .borrow_out (w_unused_borrow_min)
    );

    // Control FSM with registered running/done and keypad history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_keypad  <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_keypad <= bus.keypad;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!bus.stop_clear && bus.start && bus.door_closed && !w_time_zero) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop_clear || !bus.door_closed) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (w_dec && w_time_last) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.stop_clear) begin
                        r_state <= IDLE;
                    end else if (bus.start && bus.door_closed) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: entry, saturation, countdown, pause, reset, prescaler.
module tb_timer_counter;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    timer_counter_if bus ();

    timer_counter #(
        .CLK_HZ  (8),
        .MAX_MIN (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int t, input int o);
        chk({tag, ".min"},      32'(bus.min),      32'(m));
        chk({tag, ".sec_tens"}, 32'(bus.sec_tens), 32'(t));
        chk({tag, ".sec_ones"}, 32'(bus.sec_ones), 32'(o));
    endtask

    task automatic press(input int d);
        bus.keypad    = '0;
        bus.keypad[d] = 1'b1;
        step();
        bus.keypad = '0;
        step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.stop_clear = 1'b1;
        step();
        bus.stop_clear = 1'b0;
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.keypad      = '0;
        bus.start       = 1'b0;
        bus.stop_clear  = 1'b0;
        bus.door_closed = 1'b1;
        bus.tick_1hz    = 1'b0;
        step();
        step();
        chk_time("reset", 0, 0, 0);
        chk("reset.running", 32'(bus.running), 32'd0);
        chk("reset.done",    32'(bus.done),    32'd0);
        reset = 1'b0;
        step();

        // Key entry and shifting
        press(1); press(2); press(3);
        chk_time("keys123", 1, 2, 3);
        press(4);
        chk_time("key4", 2, 3, 4);
        bus.keypad = 10'b0000101000;
        step();
        bus.keypad = '0;
        step();
        chk_time("multihot", 2, 3, 4);

        // Saturation: tens capped at 5, minutes capped at MAX_MIN=3
        press(9);
        chk_time("key9a", 3, 4, 9);
        press(9);
        chk_time("key9b_sat", 3, 5, 9);

        pulse_clear();
        chk_time("clear1", 0, 0, 0);
        press(2); press(3); press(0);
        chk_time("keys230", 2, 3, 0);
        pulse_clear();
        chk_time("clear_idle", 0, 0, 0);

        // Start at 0:00 does nothing
        pulse_start();
        chk("start0.running", 32'(bus.running), 32'd0);
        chk("start0.done",    32'(bus.done),    32'd0);
        step();
        chk("start0.done2",   32'(bus.done),    32'd0);

        // Full countdown from 1:00
        press(1); press(0); press(0);
        chk_time("load100", 1, 0, 0);
        pulse_start();
        chk("run100.running", 32'(bus.running), 32'd1);
        tick();
        chk_time("tick059", 0, 5, 9);
        bus.tick_1hz = 1'b1;
        repeat (58) step();
        bus.tick_1hz = 1'b0;
        chk_time("tick001", 0, 0, 1);
        chk("tick001.done", 32'(bus.done), 32'd0);
        tick();
        chk_time("tick000", 0, 0, 0);
        chk("expire.done",    32'(bus.done),    32'd1);
        chk("expire.running", 32'(bus.running), 32'd0);
        step();
        chk("after.done",     32'(bus.done),    32'd0);
        chk("after.running",  32'(bus.running), 32'd0);

        // Door open pauses; tick in the same cycle is dropped
        press(3);
        chk_time("load003", 0, 0, 3);
        pulse_start();
        tick();
        chk_time("tick002", 0, 0, 2);
        bus.door_closed = 1'b0;
        bus.tick_1hz    = 1'b1;
        step();
        chk_time("door_tick", 0, 0, 2);
        chk("door.running", 32'(bus.running), 32'd0);
        repeat (3) step();
        bus.tick_1hz = 1'b0;
        chk_time("pause_ticks", 0, 0, 2);
        bus.door_closed = 1'b1;
        pulse_start();
        chk("resume.running", 32'(bus.running), 32'd1);
        press(5);
        chk_time("run_key", 0, 0, 2);
        tick();
        chk_time("resume_tick", 0, 0, 1);

        // stop_clear beats start in RUN
        bus.stop_clear = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.stop_clear = 1'b0;
        bus.start      = 1'b0;
        chk("both.running", 32'(bus.running), 32'd0);
        chk_time("both", 0, 0, 1);
        press(4);
        chk_time("pause_key", 0, 1, 4);
        pulse_clear();
        chk_time("pause_clear", 0, 0, 0);
        chk("pause_clear.running", 32'(bus.running), 32'd0);

        // Asynchronous reset mid-RUN
        press(1); press(0); press(5);
        chk_time("load105", 1, 0, 5);
        pulse_start();
        chk("run105.running", 32'(bus.running), 32'd1);
        reset = 1'b1;
        #1;
        chk_time("async_reset", 0, 0, 0);
        chk("async_reset.running", 32'(bus.running), 32'd0);
        step();
        reset = 1'b0;
        press(7);
        chk_time("post_reset_key", 0, 0, 7);

`ifdef PRESCALE_EN
        // Internal 1 Hz tick every CLK_HZ=8 cycles
        pulse_clear();
        press(2);
        chk_time("ps_load", 0, 0, 2);
        pulse_start();
        repeat (7) step();
        chk_time("ps_7", 0, 0, 2);
        step();
        chk_time("ps_8", 0, 0, 1);
        repeat (7) step();
        chk("ps_15.done", 32'(bus.done), 32'd0);
        step();
        chk_time("ps_16", 0, 0, 0);
        chk("ps_16.done", 32'(bus.done), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Producer side of the display path for the microwave oven timer.
- Encodes one-hot keypad presses into BCD digits and shifts them into the M:SS timer digits.
- Counts the timer down to 0:00 on a 1 Hz tick and drives sec_ones/sec_tens/min straight into the 7-segment decoder.
- Raises done at expiry for the cook/beeper logic.

Parameters:
- CLK_HZ, 50000000: clock frequency. Used only by the optional prescaler.
- MAX_MIN, 9: largest legal minutes digit. Entry saturates to this value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- keypad  in  10  one-hot digit keys; bit n = digit n. Level signal, already debounced.
- start  in  1  pulse; begins or resumes the countdown.
- stop_clear  in  1  pulse; pauses when running, clears digits otherwise.
- door_closed  in  1  level; countdown runs only while this is 1.
- tick_1hz  in  1  one-cycle enable, once per second. Ignored when PRESCALE_EN is defined.
- sec_ones  out  4  BCD, range 0-9.
- sec_tens  out  4  BCD, range 0-5.
- min  out  4  BCD, range 0-MAX_MIN.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on reaching 0:00.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All digits = 0; running = 0; done = 0; keypad history = 0.
- States and transitions:
  - IDLE → RUN: start with time ≠ 0:00 and door_closed = 1.
  - IDLE + start with time = 0:00: stays in IDLE, no done pulse.
  - RUN → PAUSE: stop_clear, or door_closed falls.
  - RUN → DONE: a tick decrements to 0:00.
  - PAUSE → RUN: start with door_closed = 1.
  - PAUSE → IDLE: stop_clear, which also clears the digits.
  - DONE → IDLE: next cycle, unconditionally.
- Key entry (IDLE and PAUSE only):
  - Registered copy of keypad; a press is the rising edge of (keypad ≠ 0).
  - The press is accepted only if keypad is exactly one-hot. Zero or multi-hot presses are ignored, and no new press is seen until keypad returns to 0.
  - An accepted press updates the digits on the next clock edge, applied at once:
    - min ← old sec_tens, saturated to MAX_MIN
    - sec_tens ← old sec_ones, saturated to 5
    - sec_ones ← encoded digit
  - Example: keys 1,2,3 → 1:23. Then key 4 → 2:34. Then key 9 with sec_ones = 9 → sec_tens saturates to 5.
- Countdown (RUN, on tick_1hz):
  - sec_ones > 0: decrement sec_ones.
  - sec_ones = 0, sec_tens > 0: sec_ones = 9, decrement sec_tens.
  - Both 0, min > 0: sec_ones = 9, sec_tens = 5, decrement min.
  - A tick that produces 0:00 asserts done in the same cycle the digits reach 0:00 (registered), and the state goes to DONE.
- Simultaneous events:
  - stop_clear beats start.
  - door_closed falling beats tick: no decrement that cycle.
  - Key presses during RUN are ignored.
- Latency: key press or tick to digit change is 1 cycle.
- Outputs are registered. Digits never leave BCD range, including at the saturation boundaries.

Optional Feature:
- Macro: PRESCALE_EN.
- Defined:
  - Internal counter of width clog2(CLK_HZ) produces a one-cycle tick every CLK_HZ cycles.
  - The counter is reset to 0 on reset and on any entry to RUN, so the first decrement comes a full second after start.
  - tick_1hz is ignored.
- Undefined: tick_1hz is used directly; no counter logic is synthesized.

Decomposition:
- timer_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE}
  - BCD_MAX_ONES = 9, BCD_MAX_TENS = 5
  - the onehot-to-BCD function, with a valid flag
- Sub-module bcd_down_digit:
  - Inputs: load, load_val, dec_en, max_val.
  - Outputs: value, borrow_out.
  - Instantiated three times and chained by borrow.

Test Plan:
- Reset mid-RUN at 1:05 → next cycle all digits 0, running = 0, state IDLE.
- Keys 1,2,3 then 4 → 1:23, then 2:34. Keys 3+5 pressed together → digits unchanged.
- Load 1:00, start, 1 tick → 0:59. 59 more ticks → 0:00, done high exactly 1 cycle, then IDLE.
- Load 0:03, start, 1 tick → 0:02. door_closed = 0 → PAUSE; ticks give no change. Door closed + start → RUN, resumes from 0:02.
- Start at 0:00 → stays IDLE, no done. stop_clear at 2:30 in IDLE → 0:00. stop_clear + start in the same cycle in RUN → PAUSE.
- PRESCALE_EN with CLK_HZ = 8: load 0:02, start → 0:01 after 8 cycles, 0:00 plus done after 16.
